// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and types for the data-memory arbiter: state and owner encodings,
// default bus widths and counter widths.
package dmem_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned STARVE_W   = 8;
  localparam int unsigned BURST_W    = 4;
  localparam int unsigned STAT_W     = 32;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_FORCE = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the core, DMA and memory-side signals around the arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system.
interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) ();

  logic              core_ce_i;
  logic              core_we_i;
  logic [ADDR_W-1:0] core_addr_i;
  logic [DATA_W-1:0] core_wdata_i;
  logic [DATA_W-1:0] core_rdata_o;
  logic              core_stall_o;

  logic              dma_req_i;
  logic              dma_we_i;
  logic [ADDR_W-1:0] dma_addr_i;
  logic [DATA_W-1:0] dma_wdata_i;
  logic              dma_gnt_o;
  logic              dma_rvalid_o;
  logic [DATA_W-1:0] dma_rdata_o;

  logic              mem_ce_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  core_ce_i, core_we_i, core_addr_i, core_wdata_i,
    output core_rdata_o, core_stall_o,
    input  dma_req_i, dma_we_i, dma_addr_i, dma_wdata_i,
    output dma_gnt_o, dma_rvalid_o, dma_rdata_o,
    output mem_ce_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output core_ce_i, core_we_i, core_addr_i, core_wdata_i,
    input  core_rdata_o, core_stall_o,
    output dma_req_i, dma_we_i, dma_addr_i, dma_wdata_i,
    input  dma_gnt_o, dma_rvalid_o, dma_rdata_o,
    input  mem_ce_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );

endinterface

// File: rtl/dmem_arb_starve.sv
// DMA starvation tracker: counts denied DMA cycles and opens a bounded forced-DMA window.
module dmem_arb_starve
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX  = 16,
  parameter int unsigned FORCE_BURST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic dma_req_i,
  input  logic dma_gnt_i,
  output logic force_q
);

  localparam logic [STARVE_W-1:0] STARVE_LAST = STARVE_W'(STARVE_MAX - 1);
  localparam logic [BURST_W-1:0]  BURST_LAST  = BURST_W'(FORCE_BURST - 1);

  arb_state_e          state_q, state_d;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [BURST_W-1:0]  burst_cnt_q, burst_cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_ARB;
      starve_cnt_q <= '0;
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    burst_cnt_d  = burst_cnt_q;
    case (state_q)
      ST_ARB: begin
        if (dma_req_i && !dma_gnt_i) begin
          if (starve_cnt_q == STARVE_LAST) begin
            state_d      = ST_FORCE;
            starve_cnt_d = '0;
            burst_cnt_d  = '0;
          end else begin
            starve_cnt_d = starve_cnt_q + STARVE_W'(1);
          end
        end else begin
          starve_cnt_d = '0;
        end
      end
      ST_FORCE: begin
        // A dropped request ends the window at once; otherwise every cycle here is a grant.
        if (!dma_req_i) begin
          state_d      = ST_ARB;
          starve_cnt_d = '0;
          burst_cnt_d  = '0;
        end else if (dma_gnt_i) begin
          if (burst_cnt_q == BURST_LAST) begin
            state_d      = ST_ARB;
            starve_cnt_d = '0;
            burst_cnt_d  = '0;
          end else begin
            burst_cnt_d = burst_cnt_q + BURST_W'(1);
          end
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_comb begin
    force_q = (state_q == ST_FORCE);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the core (fixed priority, zero latency) and a DMA requester.
// Optional per-event counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned STARVE_MAX  = 16,
  parameter int unsigned FORCE_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  dmem_arbiter_if.slave     bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_core_o,
  output logic [STAT_W-1:0] stat_dma_o,
  output logic [STAT_W-1:0] stat_stall_o
`endif
);

  owner_e            owner;
  logic              force_q;
  logic              dma_gnt;
  logic              stall_c;
  logic              mem_ce_c;
  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic [DATA_W-1:0] core_rdata_c;
  logic              dma_rvalid_q, dma_rvalid_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

  dmem_arb_starve #(
    .STARVE_MAX  (STARVE_MAX),
    .FORCE_BURST (FORCE_BURST)
  ) u_starve (
    .clk       (clk),
    .rst       (rst),
    .dma_req_i (bus.dma_req_i),
    .dma_gnt_i (dma_gnt),
    .force_q   (force_q)
  );

  // Per-cycle owner: a forced window beats the core, otherwise the core beats the DMA.
  always_comb begin
    owner = OWN_NONE;
    if (force_q && bus.dma_req_i) begin
      owner = OWN_DMA;
    end else if (bus.core_ce_i) begin
      owner = OWN_CORE;
    end else if (bus.dma_req_i) begin
      owner = OWN_DMA;
    end
  end

  assign dma_gnt = (owner == OWN_DMA);
  assign stall_c = force_q && bus.dma_req_i;

  always_comb begin
    mem_ce_c     = 1'b0;
    mem_we_c     = 1'b0;
    mem_addr_c   = '0;
    mem_wdata_c  = '0;
    core_rdata_c = '0;
    case (owner)
      OWN_CORE: begin
        mem_ce_c     = 1'b1;
        mem_we_c     = bus.core_we_i;
        mem_addr_c   = bus.core_addr_i;
        mem_wdata_c  = bus.core_wdata_i;
        core_rdata_c = bus.mem_rdata_i;
      end
      OWN_DMA: begin
        mem_ce_c    = 1'b1;
        mem_we_c    = bus.dma_we_i;
        mem_addr_c  = bus.dma_addr_i;
        mem_wdata_c = bus.dma_wdata_i;
      end
      default: ;
    endcase
  end

  // DMA read data is captured at the grant edge and flagged for exactly one cycle.
  always_comb begin
    dma_rvalid_d = dma_gnt && !bus.dma_we_i;
    dma_rdata_d  = dma_rvalid_d ? bus.mem_rdata_i : dma_rdata_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dma_rvalid_q <= 1'b0;
      dma_rdata_q  <= '0;
    end else begin
      dma_rvalid_q <= dma_rvalid_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  assign bus.mem_ce_o     = mem_ce_c;
  assign bus.mem_we_o     = mem_we_c;
  assign bus.mem_addr_o   = mem_addr_c;
  assign bus.mem_wdata_o  = mem_wdata_c;
  assign bus.core_rdata_o = core_rdata_c;
  assign bus.core_stall_o = stall_c;
  assign bus.dma_gnt_o    = dma_gnt;
  assign bus.dma_rvalid_o = dma_rvalid_q;
  assign bus.dma_rdata_o  = dma_rdata_q;

`ifdef DMEM_ARB_STATS_EN
  logic [STAT_W-1:0] stat_core_q, stat_core_d;
  logic [STAT_W-1:0] stat_dma_q, stat_dma_d;
  logic [STAT_W-1:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_core_d  = stat_core_q + STAT_W'(owner == OWN_CORE);
    stat_dma_d   = stat_dma_q + STAT_W'(dma_gnt);
    stat_stall_d = stat_stall_q + STAT_W'(stall_c);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_core_q  <= '0;
      stat_dma_q   <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_core_q  <= stat_core_d;
      stat_dma_q   <= stat_dma_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_core_o  = stat_core_q;
  assign stat_dma_o   = stat_dma_q;
  assign stat_stall_o = stat_stall_q;
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data_mem port between the riscv core data interface and a secondary DMA/debug requester, for example a memory loader or dump engine.
- The core has fixed priority, and its accesses pass through combinationally with zero added latency.
- The DMA port uses a req/gnt handshake. A starvation counter forces DMA bursts and stalls the core through core_stall_o.
- Sits between riscv0 and data_mem0 in riscv_soc.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
STARVE_MAX, 16, consecutive denied DMA cycles before forcing (legal range 1..255)
FORCE_BURST, 4, maximum DMA beats granted per forced window (legal range 1..15)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous reset, active-low
core_ce_i  in  1  core data access enable
core_we_i  in  1  core write enable
core_addr_i  in  ADDR_W  core address
core_wdata_i  in  DATA_W  core write data
core_rdata_o  out  DATA_W  core read data
core_stall_o  out  1  core must hold its request and freeze the pipeline
dma_req_i  in  1  DMA access request; held until granted
dma_we_i  in  1  DMA write enable
dma_addr_i  in  ADDR_W  DMA address
dma_wdata_i  in  DATA_W  DMA write data
dma_gnt_o  out  1  DMA access performed this cycle
dma_rvalid_o  out  1  registered read-data-valid pulse
dma_rdata_o  out  DATA_W  registered DMA read data
mem_ce_o  out  1  to data_mem ce
mem_we_o  out  1  to data_mem we
mem_addr_o  out  ADDR_W  to data_mem addr
mem_wdata_o  out  DATA_W  to data_mem data_i
mem_rdata_i  in  DATA_W  from data_mem data_o; combinational read

Behaviour:
- The memory reads combinationally and writes at posedge when ce&we.
- The per-cycle owner is decided combinationally:
  - FORCE state with dma_req_i=1 -> DMA.
  - Otherwise core_ce_i=1 -> core.
  - Otherwise dma_req_i=1 -> DMA.
  - Otherwise no owner.
- Outputs by owner:
  - core owner: mem_* = core_*, and core_rdata_o = mem_rdata_i.
  - DMA owner: mem_* = dma_*, dma_gnt_o=1, and core_rdata_o=0.
  - no owner: mem_ce_o=0, all mem_* = 0.
- A DMA access completes in its grant cycle; writes commit at that edge.
- DMA reads: mem_rdata_i is registered into dma_rdata_o at the grant edge, and dma_rvalid_o=1 for exactly the next cycle. DMA writes produce no rvalid.
- core_stall_o = (state==FORCE) && dma_req_i. It is combinational; the core must keep core_* stable while stalled.
- FSM states: ARB and FORCE. starve_cnt is 8 bits; burst_cnt is 4 bits.
- In ARB:
  - starve_cnt increments on each cycle with dma_req_i && !dma_gnt_o.
  - starve_cnt clears on any DMA grant or when dma_req_i=0.
  - Transition to FORCE when starve_cnt==STARVE_MAX-1 and the DMA is denied this cycle; on that transition burst_cnt=0.
- In FORCE:
  - Each DMA grant increments burst_cnt.
  - Return to ARB after the grant with burst_cnt==FORCE_BURST-1, or in any cycle with dma_req_i=0.
  - starve_cnt=0 on exit.
- Boundary cases:
  - Simultaneous core and DMA requests in ARB: the core wins.
  - With STARVE_MAX=1, a single denied cycle forces.
  - A DMA request dropped mid-burst ends FORCE that same cycle, with no stall.
- Reset state: state=ARB, starve_cnt=0, burst_cnt=0, dma_rvalid_o=0, dma_rdata_o=0. Combinational outputs follow from this state.
- Reset asserted mid-burst aborts immediately. A DMA read granted in the reset cycle never produces rvalid.

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- When defined, adds three outputs, each 32 bits:
  - stat_core_o: count of core accesses.
  - stat_dma_o: count of DMA grants.
  - stat_stall_o: count of cycles with core_stall_o=1.
- The counters wrap at 2^32 and are cleared by reset.
- When undefined, these ports and counters do not exist; the rest of the behaviour is identical.

Decomposition:
- Shared package: the state encoding constants ST_ARB=1'b0 and ST_FORCE=1'b1, and the ADDR_W/DATA_W defaults, shared with the riscv/data_mem defines.
- One natural sub-module, dmem_arb_starve: owns starve_cnt, burst_cnt and the FSM, and outputs force_q. The top holds the owner mux and the read-data register.

Test Plan:
1. Core-only traffic: write 0xDEADBEEF to addr 0x10, then read it -> core_rdata_o=0xDEADBEEF in the same cycle; dma_gnt_o stays 0 and core_stall_o stays 0.
2. DMA-only traffic: write 0x12345678 to addr 0x20, then read it -> gnt in each request cycle; dma_rvalid_o pulses one cycle after the read grant with dma_rdata_o=0x12345678.
3. Core holds ce continuously while dma_req_i is held -> no grant for 16 cycles; cycle 17 enters FORCE with 4 grants and core_stall_o=1 for 4 cycles; then ARB resumes, the core wins, and starve_cnt restarts from 0.
4. In FORCE, dma_req_i drops after 2 beats -> core_stall_o falls in that same cycle, and the core access to addr 0x30 proceeds.
5. Async reset asserted during the 2nd forced beat (a DMA read) -> all registers clear immediately; no rvalid; stall=0; after release, the core is granted normally.
6. Simultaneous first core and DMA request with STARVE_MAX=1 -> the core wins cycle 0; the DMA is granted in cycle 1 with stall=1.
